// File: rtl/enemy_scheduler.sv
// Enemy slot array for the shooter: frame-timed spawning, descent, hit retirement, score and level.
// Optional build macro SCHED_BURST_EN lets each spawn attempt fill up to two free slots.
module enemy_scheduler #(
  parameter int          N_ENEMY         = 8,
  parameter int          SPAWN_PERIOD    = 60,
  parameter int          STEP_INIT       = 1,
  parameter int          STEP_MAX        = 4,
  parameter int          KILLS_PER_LEVEL = 10,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       gameover,
  input  logic                       frame_tick,
  input  logic [N_ENEMY-1:0]         hit,
  output logic [N_ENEMY-1:0]         enemy_alive,
  output logic [N_ENEMY-1:0][9:0]    enemy_x,
  output logic [N_ENEMY-1:0][8:0]    enemy_y,
  output logic [2:0]                 step,
  output logic [15:0]                score,
  output logic                       running
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FREEZE = 2'd2
  } state_t;

  localparam logic [15:0]        SPAWN_LAST = 16'(SPAWN_PERIOD - 1);
  localparam logic [15:0]        KPL        = 16'(KILLS_PER_LEVEL);
  localparam logic [2:0]         STEP_START = 3'(STEP_INIT);
  localparam logic [2:0]         STEP_TOP   = 3'(STEP_MAX);
  localparam logic [N_ENEMY-1:0] ONE_V      = {{(N_ENEMY-1){1'b0}}, 1'b1};

  state_t                    state_r, state_s;
  logic [N_ENEMY-1:0]        alive_r, alive_s;
  logic [N_ENEMY-1:0][9:0]   x_r, x_s;
  logic [N_ENEMY-1:0][8:0]   y_r, y_s;
  logic [2:0]                step_r, step_s;
  logic [15:0]               score_r, score_s;
  logic [15:0]               kill_cnt_r, kill_cnt_s;
  logic [15:0]               spawn_cnt_r, spawn_cnt_s;
  logic [15:0]               lfsr_r, lfsr_s;
  logic                      running_r;
  logic [N_ENEMY-1:0]        kill_s, free_s, first_s, spawn_mask_s;
  logic [15:0]               kill_num_s, kill_sum_s;
  logic [16:0]               score_sum_s;
  logic [9:0]                x_lo_s, x_hi_s;
`ifdef SCHED_BURST_EN
  logic [N_ENEMY-1:0]        rest_s, second_s;
`endif

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] popcount(input logic [N_ENEMY-1:0] v);
    logic [15:0] c;
    c = 16'd0;
    for (int i = 0; i < N_ENEMY; i++) begin
      c = c + {15'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [8:0] descend(input logic [8:0] y, input logic [2:0] s);
    logic [9:0] sum;
    sum = {1'b0, y} + {7'd0, s};
    return sum[9] ? 9'd511 : sum[8:0];
  endfunction

  // Spawn candidates, chosen from occupancy before this cycle's hits.
  always_comb begin
    free_s  = ~alive_r;
    first_s = free_s & (~free_s + ONE_V);
`ifdef SCHED_BURST_EN
    rest_s       = free_s & ~first_s;
    second_s     = rest_s & (~rest_s + ONE_V);
    spawn_mask_s = first_s | second_s;
`else
    spawn_mask_s = first_s;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_s     = state_r;
    alive_s     = alive_r;
    x_s         = x_r;
    y_s         = y_r;
    step_s      = step_r;
    score_s     = score_r;
    kill_cnt_s  = kill_cnt_r;
    spawn_cnt_s = spawn_cnt_r;
    lfsr_s      = lfsr_next(lfsr_r);
    kill_s      = hit & alive_r;
    kill_num_s  = popcount(kill_s);
    kill_sum_s  = kill_cnt_r + kill_num_s;
    score_sum_s = {1'b0, score_r} + {1'b0, kill_num_s};
    x_lo_s      = {1'b0, lfsr_r[8:0]} + 10'd48;
    x_hi_s      = {1'b0, lfsr_r[15:7]} + 10'd48;
    case (state_r)
      S_IDLE, S_FREEZE: begin
        if (start) begin
          state_s     = S_RUN;
          alive_s     = '0;
          x_s         = '0;
          y_s         = '0;
          step_s      = STEP_START;
          score_s     = 16'd0;
          kill_cnt_s  = 16'd0;
          spawn_cnt_s = 16'd0;
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (gameover) begin
          state_s = S_FREEZE;
        end else begin
          alive_s = alive_r & ~kill_s;
          if (frame_tick) begin
            // A same-cycle hit beats movement; freshly spawned slots do not move.
            for (int i = 0; i < N_ENEMY; i++) begin
              if (alive_r[i] && !kill_s[i]) begin
                y_s[i] = descend(y_r[i], step_r);
              end else begin
                y_s[i] = y_r[i];
              end
            end
            if (spawn_cnt_r == SPAWN_LAST) begin
              spawn_cnt_s = 16'd0;
              for (int i = 0; i < N_ENEMY; i++) begin
                if (spawn_mask_s[i]) begin
                  alive_s[i] = 1'b1;
                  y_s[i]     = 9'd0;
                  x_s[i]     = first_s[i] ? x_lo_s : x_hi_s;
                end else begin
                  x_s[i] = x_r[i];
                end
              end
            end else begin
              spawn_cnt_s = spawn_cnt_r + 16'd1;
            end
          end else begin
            spawn_cnt_s = spawn_cnt_r;
          end
          score_s = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
          if (kill_sum_s >= KPL) begin
            kill_cnt_s = kill_sum_s - KPL;
            step_s     = (step_r < STEP_TOP) ? step_r + 3'd1 : step_r;
          end else begin
            kill_cnt_s = kill_sum_s;
          end
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      alive_r     <= '0;
      x_r         <= '0;
      y_r         <= '0;
      step_r      <= STEP_START;
      score_r     <= 16'd0;
      kill_cnt_r  <= 16'd0;
      spawn_cnt_r <= 16'd0;
      lfsr_r      <= LFSR_SEED;
      running_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      alive_r     <= alive_s;
      x_r         <= x_s;
      y_r         <= y_s;
      step_r      <= step_s;
      score_r     <= score_s;
      kill_cnt_r  <= kill_cnt_s;
      spawn_cnt_r <= spawn_cnt_s;
      lfsr_r      <= lfsr_s;
      running_r   <= (state_s == S_RUN);
    end
  end

  assign enemy_alive = alive_r;
  assign enemy_x     = x_r;
  assign enemy_y     = y_r;
  assign step        = step_r;
  assign score       = score_r;
  assign running     = running_r;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Testbench for enemy_scheduler: directed vector table, corner sequences and a
// randomized run checked against a behavioural game model.
module tb_enemy_scheduler;
  localparam int NE  = 8;
  localparam int SP  = 4;
  localparam int KPL = 2;
  localparam int SMX = 4;

  logic                 clk = 1'b0;
  logic                 reset_n, start, gameover, frame_tick;
  logic [NE-1:0]        hit;
  logic [NE-1:0]        enemy_alive;
  logic [NE-1:0][9:0]   enemy_x;
  logic [NE-1:0][8:0]   enemy_y;
  logic [2:0]           step;
  logic [15:0]          score;
  logic                 running;

  int n_cmp = 0;
  int n_err = 0;

  enemy_scheduler #(.N_ENEMY(NE), .SPAWN_PERIOD(SP), .STEP_INIT(1), .STEP_MAX(SMX),
                    .KILLS_PER_LEVEL(KPL), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .gameover(gameover),
    .frame_tick(frame_tick), .hit(hit), .enemy_alive(enemy_alive),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .step(step), .score(score), .running(running));

  always #5 clk = ~clk;

  // Behavioural model of the game rules
  localparam int IDLE = 0, RUN = 1, FREEZE = 2;
  bit [NE-1:0] m_alive;
  int          m_x[NE];
  int          m_y[NE];
  int          m_step, m_score, m_kc, m_cnt, m_state;
  bit [15:0]   m_lfsr;

  function automatic bit [15:0] lfsr_adv(bit [15:0] v);
    bit [15:0] taps;
    taps = 16'h0000;
    taps[16-1] = 1'b1; taps[14-1] = 1'b1; taps[13-1] = 1'b1; taps[11-1] = 1'b1;
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

  task automatic model_clear();
    m_alive = '0;
    for (int i = 0; i < NE; i++) begin m_x[i] = 0; m_y[i] = 0; end
    m_step = 1; m_score = 0; m_kc = 0; m_cnt = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_state = IDLE;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    bit [NE-1:0] pre;
    bit [15:0]   cur;
    int          k;
    if (!reset_n) begin
      model_reset();
    end else begin
      cur = m_lfsr;
      m_lfsr = lfsr_adv(m_lfsr);
      if (m_state != RUN) begin
        if (start) begin model_clear(); m_state = RUN; end
      end else if (gameover) begin
        m_state = FREEZE;
      end else begin
        pre = m_alive;
        k = 0;
        for (int i = 0; i < NE; i++)
          if (hit[i] && pre[i]) begin m_alive[i] = 1'b0; k++; end
        if (frame_tick) begin
          for (int i = 0; i < NE; i++)
            if (pre[i] && m_alive[i]) m_y[i] = (m_y[i] + m_step > 511) ? 511 : m_y[i] + m_step;
          if (m_cnt == SP - 1) begin
            m_cnt = 0;
            for (int i = 0; i < NE; i++)
              if (!pre[i]) begin
                m_alive[i] = 1'b1; m_y[i] = 0; m_x[i] = int'(cur % 512) + 48;
                break;
              end
          end else begin
            m_cnt++;
          end
        end
        m_score = (m_score + k > 65535) ? 65535 : m_score + k;
        m_kc += k;
        if (m_kc >= KPL) begin
          m_kc -= KPL;
          if (m_step < SMX) m_step++;
        end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("alive", 32'(enemy_alive), 32'(m_alive));
    check("step", 32'(step), m_step);
    check("score", 32'(score), m_score);
    check("running", 32'(running), 32'(m_state == RUN));
    for (int i = 0; i < NE; i++) begin
      check($sformatf("x%0d", i), 32'(enemy_x[i]), m_x[i]);
      check($sformatf("y%0d", i), 32'(enemy_y[i]), m_y[i]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_in(bit st, bit go, bit ft, logic [NE-1:0] h);
    start = st; gameover = go; frame_tick = ft; hit = h;
  endtask

  typedef struct {
    int st; int go; int ft; int hit;
    int e_alive; int e_y0; int e_score; int e_step; int e_run;
  } vec_t;
  vec_t vt[13];

  initial begin
    int iter;
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    vt[1]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
    vt[2]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
    vt[3]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
    vt[4]  = '{0, 0, 1, 0, 1, 0, 0, 1, 1};
    vt[5]  = '{0, 0, 1, 0, 1, 1, 0, 1, 1};
    vt[6]  = '{0, 0, 1, 0, 1, 2, 0, 1, 1};
    vt[7]  = '{0, 0, 1, 0, 1, 3, 0, 1, 1};
    vt[8]  = '{0, 0, 1, 0, 3, 4, 0, 1, 1};
    vt[9]  = '{0, 0, 0, 7, 0, 4, 2, 2, 1};
    vt[10] = '{0, 0, 0, 1, 0, 4, 2, 2, 1};
    vt[11] = '{0, 1, 0, 0, 0, 4, 2, 2, 0};
    vt[12] = '{1, 0, 0, 0, 0, 0, 0, 1, 1};

    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    tick();
    tick();
    check("rst_alive", 32'(enemy_alive), 32'd0);
    check("rst_step", 32'(step), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    reset_n = 1'b1;

    // Directed vector table
    for (int r = 0; r < 13; r++) begin
      set_in(vt[r].st[0], vt[r].go[0], vt[r].ft[0], 8'(vt[r].hit));
      tick();
      check($sformatf("tbl%0d_alive", r), 32'(enemy_alive), vt[r].e_alive);
      check($sformatf("tbl%0d_y0", r), 32'(enemy_y[0]), vt[r].e_y0);
      check($sformatf("tbl%0d_score", r), 32'(score), vt[r].e_score);
      check($sformatf("tbl%0d_step", r), 32'(step), vt[r].e_step);
      check($sformatf("tbl%0d_run", r), 32'(running), vt[r].e_run);
      if (r == 4) check("tbl4_x0_range", 32'(enemy_x[0] >= 10'd48 && enemy_x[0] <= 10'd559), 32'd1);
    end

    // Descent saturation: keep slot 0, kill every other arrival to raise the step
    iter = 0;
    while (m_y[0] != 511 && iter < 1000) begin
      set_in(1'b0, 1'b0, 1'b1, m_alive & 8'hFE);
      tick();
      iter++;
    end
    check("sat_reached", 32'(iter < 1000), 32'd1);
    check("sat_y0", 32'(enemy_y[0]), 32'd511);
    check("sat_alive0", 32'(enemy_alive[0]), 32'd1);
    check("sat_step", 32'(step), 32'd4);

    // Full array: skipped spawn, same-cycle hit on slot 3
    set_in(1'b0, 1'b1, 1'b0, '0); tick();
    set_in(1'b1, 1'b0, 1'b0, '0); tick();
    for (int i = 0; i < 35; i++) begin set_in(1'b0, 1'b0, 1'b1, '0); tick(); end
    check("full_alive", 32'(enemy_alive), 32'hFF);
    set_in(1'b0, 1'b0, 1'b1, 8'h08); tick();
    check("full_hit3", 32'(enemy_alive), 32'hF7);
    check("full_score", 32'(score), 32'd1);

    // Freeze then restart
    set_in(1'b0, 1'b1, 1'b0, '0); tick();
    check("frz_running", 32'(running), 32'd0);
    for (int i = 0; i < 5; i++) begin set_in(1'b0, 1'b0, 1'b1, 8'hFF); tick(); end
    check("frz_alive", 32'(enemy_alive), 32'hF7);
    check("frz_score", 32'(score), 32'd1);
    set_in(1'b1, 1'b0, 1'b0, '0); tick();
    check("restart_running", 32'(running), 32'd1);
    check("restart_alive", 32'(enemy_alive), 32'd0);

    // Asynchronous reset mid-run
    for (int i = 0; i < 12; i++) begin set_in(1'b0, 1'b0, 1'b1, 8'h02); tick(); end
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_alive", 32'(enemy_alive), 32'd0);
    check("arst_score", 32'(score), 32'd0);
    check("arst_step", 32'(step), 32'd1);
    check("arst_running", 32'(running), 32'd0);
    model_reset();
    set_in(1'b0, 1'b0, 1'b0, '0);
    tick();
    reset_n = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, '0); tick();
    check("arst_start", 32'(running), 32'd1);

    // Randomized play against the model
    for (int c = 0; c < 3000; c++) begin
      start      = (m_state != RUN) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
      gameover   = ($urandom_range(0, 299) == 0);
      frame_tick = $urandom_range(0, 1) == 1;
      hit        = 8'($urandom) & 8'($urandom) & 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
